// File: rtl/ex_operand_stage_if.sv
// ============================================================================
// Module      : ex_operand_stage_if
// Description : Decode-stage bundle handed from ID into the ID/EX operand stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_operand_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
);
  logic                     id_valid;
  logic [DATA_WIDTH-1:0]    id_pc;
  logic [DATA_WIDTH-1:0]    id_rs1_data;
  logic [DATA_WIDTH-1:0]    id_rs2_data;
  logic [DATA_WIDTH-1:0]    id_imm;
  logic [REG_ADDR_W-1:0]    id_rs1_addr;
  logic [REG_ADDR_W-1:0]    id_rs2_addr;
  logic [REG_ADDR_W-1:0]    id_rd_addr;
  logic [1:0]               id_a_sel;
  logic                     id_b_imm;
  logic [OPCODE_LENGTH-1:0] id_alu_op;
  logic                     id_reg_write;
  logic                     id_mem_read;
  logic                     id_mem_write;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_a_sel, id_b_imm,
           id_alu_op, id_reg_write, id_mem_read, id_mem_write
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_a_sel, id_b_imm,
           id_alu_op, id_reg_write, id_mem_read, id_mem_write
  );
endinterface

`default_nettype wire

// File: rtl/ex_operand_stage.sv
// ============================================================================
// Module      : ex_operand_stage
// Description : ID/EX register with MEM/WB forwarding, load-use bubbles and
//               ALU operand select. EX_PERF_CNT_EN enables perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  ex_operand_stage_if.slave             dec,
  input  wire logic                     stall,
  input  wire logic                     flush,
  input  wire logic [REG_ADDR_W-1:0]    mem_rd_addr,
  input  wire logic                     mem_reg_write,
  input  wire logic [DATA_WIDTH-1:0]    mem_result,
  input  wire logic [REG_ADDR_W-1:0]    wb_rd_addr,
  input  wire logic                     wb_reg_write,
  input  wire logic [DATA_WIDTH-1:0]    wb_result,
  output logic      [DATA_WIDTH-1:0]    SrcA,
  output logic      [DATA_WIDTH-1:0]    SrcB,
  output logic      [OPCODE_LENGTH-1:0] Operation,
  output logic                          ex_valid,
  output logic      [REG_ADDR_W-1:0]    ex_rd_addr,
  output logic                          ex_reg_write,
  output logic                          ex_mem_read,
  output logic                          ex_mem_write,
  output logic      [DATA_WIDTH-1:0]    ex_store_data,
  output logic                          load_use_stall,
  output logic      [31:0]              bubble_count,
  output logic      [31:0]              fwd_count
);

  localparam logic [OPCODE_LENGTH-1:0] c_OP_ADD = OPCODE_LENGTH'(4'b0010);

  logic                     r_valid;
  logic [DATA_WIDTH-1:0]    r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [REG_ADDR_W-1:0]    r_rs1_addr, r_rs2_addr, r_rd_addr;
  logic [1:0]               r_a_sel;
  logic                     r_b_imm;
  logic [OPCODE_LENGTH-1:0] r_alu_op;
  logic                     r_reg_write, r_mem_read, r_mem_write;

  logic                     w_load_use;
  logic                     w_rs1_mem_hit, w_rs1_wb_hit, w_rs2_mem_hit, w_rs2_wb_hit;
  logic [DATA_WIDTH-1:0]    w_rs1_fwd, w_rs2_fwd;
  logic [DATA_WIDTH-1:0]    w_src_a;

  assign w_load_use = dec.id_valid & r_valid & r_mem_read & (r_rd_addr != '0) &
                      ((r_rd_addr == dec.id_rs1_addr) | (r_rd_addr == dec.id_rs2_addr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd_addr   <= '0;
      r_a_sel     <= 2'b00;
      r_b_imm     <= 1'b0;
      r_alu_op    <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (flush || (!stall && w_load_use)) begin
      // Bubble: data fields are left as-is, only the control that has side effects is killed.
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (!stall) begin
      r_valid     <= dec.id_valid;
      r_pc        <= dec.id_pc;
      r_rs1_data  <= dec.id_rs1_data;
      r_rs2_data  <= dec.id_rs2_data;
      r_imm       <= dec.id_imm;
      r_rs1_addr  <= dec.id_rs1_addr;
      r_rs2_addr  <= dec.id_rs2_addr;
      r_rd_addr   <= dec.id_rd_addr;
      r_a_sel     <= dec.id_a_sel;
      r_b_imm     <= dec.id_b_imm;
      r_alu_op    <= dec.id_alu_op;
      r_reg_write <= dec.id_reg_write;
      r_mem_read  <= dec.id_mem_read;
      r_mem_write <= dec.id_mem_write;
    end
  end

  // x0 is hard-wired, so a zero destination never produces a forward.
  assign w_rs1_mem_hit = mem_reg_write & (mem_rd_addr != '0) & (mem_rd_addr == r_rs1_addr);
  assign w_rs1_wb_hit  = wb_reg_write  & (wb_rd_addr  != '0) & (wb_rd_addr  == r_rs1_addr);
  assign w_rs2_mem_hit = mem_reg_write & (mem_rd_addr != '0) & (mem_rd_addr == r_rs2_addr);
  assign w_rs2_wb_hit  = wb_reg_write  & (wb_rd_addr  != '0) & (wb_rd_addr  == r_rs2_addr);

  assign w_rs1_fwd = w_rs1_mem_hit ? mem_result : (w_rs1_wb_hit ? wb_result : r_rs1_data);
  assign w_rs2_fwd = w_rs2_mem_hit ? mem_result : (w_rs2_wb_hit ? wb_result : r_rs2_data);

  always_comb begin
    w_src_a = '0;
    case (r_a_sel)
      2'b00:   w_src_a = w_rs1_fwd;
      2'b01:   w_src_a = r_pc;
      default: w_src_a = '0;
    endcase
  end

  assign SrcA           = r_valid ? w_src_a : '0;
  assign SrcB           = r_valid ? (r_b_imm ? r_imm : w_rs2_fwd) : '0;
  assign Operation      = r_valid ? r_alu_op : c_OP_ADD;
  assign ex_valid       = r_valid;
  assign ex_rd_addr     = r_rd_addr;
  assign ex_reg_write   = r_valid & r_reg_write;
  assign ex_mem_read    = r_valid & r_mem_read;
  assign ex_mem_write   = r_valid & r_mem_write;
  assign ex_store_data  = w_rs2_fwd;
  assign load_use_stall = w_load_use;

`ifdef EX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_fwd_cnt;
  logic        w_fwd_used;

  // An operand counts as forwarded only when the forwarded value actually feeds SrcA, SrcB or store data.
  assign w_fwd_used = ((r_a_sel == 2'b00) & (w_rs1_mem_hit | w_rs1_wb_hit)) |
                      ((~r_b_imm | r_mem_write) & (w_rs2_mem_hit | w_rs2_wb_hit));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bubble_cnt <= '0;
      r_fwd_cnt    <= '0;
    end else begin
      if ((flush || w_load_use) && !stall)
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (r_valid && !stall && w_fwd_used)
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  end

  assign bubble_count = r_bubble_cnt;
  assign fwd_count    = r_fwd_cnt;
`else
  assign bubble_count = '0;
  assign fwd_count    = '0;
`endif

endmodule

`default_nettype wire
